// File: rtl/serial_subtractor8.sv
// serial_subtractor8
//   Bit-serial subtractor: Diff = A - B - Bin, processed LSB first, one bit
//   per clock through a single full-subtractor cell and a borrow flop.
//   Results and flags update only on the edge that enters DONE and hold
//   their values through IDLE and through the next SHIFT phase.
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request; accepted only in IDLE or DONE
//   A, B   : minuend / subtrahend, captured on the accepting edge
//   Bin    : borrow-in, captured on the accepting edge
//   busy   : high while bits are being processed
//   done   : one-cycle pulse, result outputs valid
//   Diff   : A - B - Bin modulo 2^WIDTH
//   Bout   : unsigned borrow-out
//   Ovf    : signed overflow
//   Zero   : Diff == 0
module serial_subtractor8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
  logic             borrow, borrow_nxt;
  logic [CW-1:0]    cnt;
  logic             accept, last_bit;
  logic             bit_a, bit_b, bit_d;

  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

  always_comb begin
    accept   = start && (state != S_SHIFT);
    last_bit = (state == S_SHIFT) && (cnt == LAST);
  end

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    bit_a      = a_sh[0];
    bit_b      = b_sh[0];
    bit_d      = bit_a ^ bit_b ^ borrow;
    borrow_nxt = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow);
    res_nxt    = {bit_d, res_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SHIFT;
      S_SHIFT: if (last_bit) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_SHIFT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      Diff   <= '0;
      Bout   <= 1'b0;
      Ovf    <= 1'b0;
      Zero   <= 1'b0;
    end else if (accept) begin
      a_sh   <= A;
      b_sh   <= B;
      borrow <= Bin;
      cnt    <= '0;
    end else if (state == S_SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nxt;
      borrow <= borrow_nxt;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        // borrow still holds the borrow into the MSB here.
        Diff <= res_nxt;
        Bout <= borrow_nxt;
        Ovf  <= borrow ^ borrow_nxt;
        Zero <= (res_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor8.sv
module tb_serial_subtractor8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] A, B;
  logic       Bin;
  logic       busy, done;
  logic [7:0] Diff;
  logic       Bout, Ovf, Zero;

  int errors = 0;
  int checks = 0;
  logic [7:0] prev_diff = 8'h00;

  serial_subtractor8 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
    .busy(busy), .done(done), .Diff(Diff), .Bout(Bout), .Ovf(Ovf), .Zero(Zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b;
    logic       bin;
    logic [7:0] d;
    logic       bo, ov, z;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output logic [7:0] d, output logic bo, output logic ov,
                       output logic z);
    int u, s;
    u  = int'(a) - int'(b) - int'(bin);
    s  = int'($signed(a)) - int'($signed(b)) - int'(bin);
    d  = u[7:0];
    bo = (u < 0);
    ov = (s > 127) || (s < -128);
    z  = (d == 8'h00);
  endtask

  // Waits from just after the accepting edge until done is seen; k = edges counted.
  task automatic wait_done(input string nm, output int k);
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (done) begin
        k = i;
        return;
      end
      if (i == 4) chk({nm, "_hold"}, Diff, prev_diff);
    end
    chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input logic [7:0] ed, input logic ebo,
                        input logic eov, input logic ez);
    int k;
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = ~a; B = ~b; Bin = ~bin;  // operands must already be latched
    chk({nm, "_busy"}, busy, 1);
    wait_done(nm, k);
    chk({nm, "_lat"}, k, 8);
    chk({nm, "_diff"}, Diff, ed);
    chk({nm, "_bout"}, Bout, ebo);
    chk({nm, "_ovf"}, Ovf, eov);
    chk({nm, "_zero"}, Zero, ez);
    chk({nm, "_busy0"}, busy, 0);
    prev_diff = ed;
  endtask

  initial begin
    vec_t vt[8];
    logic [7:0] ed, ra, rb;
    logic ebo, eov, ez, rbin;
    int k, pulses;
    logic [7:0] seen;

    vt[0] = '{8'h3C, 8'h1A, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0};
    vt[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vt[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    vt[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
    vt[4] = '{8'h55, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vt[5] = '{8'h55, 8'h55, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vt[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vt[7] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", {Diff, Bout, Ovf, Zero}, 0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_done", done, 0);

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].bin,
             vt[i].d, vt[i].bo, vt[i].ov, vt[i].z);

    // start while busy is ignored
    @(posedge clk); #1;
    A = 8'h10; B = 8'h01; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    A = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0; seen = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        pulses++;
        seen = Diff;
      end
      @(posedge clk); #1;
    end
    chk("ign_pulses", pulses, 1);
    chk("ign_diff", seen, 8'h0F);
    prev_diff = 8'h0F;

    // start held high: back-to-back operations every 9 cycles
    ra = 8'hA5; rb = 8'h3C; rbin = 1'b1;
    A = ra; B = rb; Bin = rbin; start = 1'b1;
    @(posedge clk); #1;
    for (int op = 0; op < 3; op++) begin
      model(ra, rb, rbin, ed, ebo, eov, ez);
      chk("b2b_done0", done, 0);
      wait_done("b2b", k);
      chk("b2b_lat", k, 8);
      chk("b2b_diff", Diff, ed);
      chk("b2b_flags", {Bout, Ovf, Zero}, {ebo, eov, ez});
      prev_diff = ed;
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      A = ra; B = rb; Bin = rbin;
      if (op == 2) start = 1'b0;
      @(posedge clk); #1;
    end
    chk("b2b_idle", {busy, done}, 2'b00);

    // reset mid-operation
    A = 8'h3C; B = 8'h1A; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_out", {done, Diff, Bout, Ovf, Zero}, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    chk("abort_nodone", pulses, 0);
    prev_diff = 8'h00;

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      if (i % 50 == 0) rb = ra;
      model(ra, rb, rbin, ed, ebo, eov, ez);
      run_op("rnd", ra, rb, rbin, ed, ebo, eov, ez);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
